// File: rtl/shift_sequencer.sv
// Sequences an external shift register through load, shift and capture for one shift request.
// Done arrives 4 cycles after start, or 3 when a zero amount skips SHIFT.
// Start is only sampled in IDLE and is ignored while busy.
module shift_sequencer #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        use_var,
    input  logic [4:0]  shamt,
    input  logic [31:0] rs_amt,
    input  logic [31:0] data_in,
    input  logic [31:0] shifter_out,
    output logic [2:0]  shifter_ctrl,
    output logic [4:0]  shifter_n,
    output logic [31:0] shifter_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [2:0] CTRL_HOLD = 3'b000;
    localparam logic [2:0] CTRL_LOAD = 3'b001;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [2:0]  shifter_ctrl_q, shifter_ctrl_d;
    logic [4:0]  shifter_n_q, shifter_n_d;
    logic [31:0] shifter_in_q, shifter_in_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic        illegal_q, illegal_d;

    // Only the low five bits of the register amount are meaningful.
    logic        unused_rs_amt_hi;
    assign unused_rs_amt_hi = ^rs_amt[31:5];

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        shifter_ctrl_d = CTRL_HOLD;
        shifter_n_d    = shifter_n_q;
        shifter_in_d   = shifter_in_q;
        done_d         = 1'b0;
        result_d       = result_q;
        illegal_d      = 1'b0;

        // Outputs are registered, so each branch sets what the next state must present.
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_ILLEGAL) begin
                        illegal_d = 1'b1;
                    end else begin
                        op_d           = op;
                        shifter_n_d    = use_var ? rs_amt[4:0] : shamt;
                        shifter_in_d   = data_in;
                        shifter_ctrl_d = CTRL_LOAD;
                        state_d        = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (SKIP_ZERO && (shifter_n_q == 5'd0)) begin
                    state_d = S_CAPTURE;
                end else begin
                    shifter_ctrl_d = {1'b0, op_q} + 3'd2;
                    state_d        = S_SHIFT;
                end
            end
            S_SHIFT: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                result_d = shifter_out;
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            op_q           <= 2'b00;
            shifter_ctrl_q <= CTRL_HOLD;
            shifter_n_q    <= 5'd0;
            shifter_in_q   <= 32'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_q       <= 32'd0;
            illegal_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            shifter_ctrl_q <= shifter_ctrl_d;
            shifter_n_q    <= shifter_n_d;
            shifter_in_q   <= shifter_in_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            result_q       <= result_d;
            illegal_q      <= illegal_d;
        end
    end

    assign shifter_ctrl = shifter_ctrl_q;
    assign shifter_n    = shifter_n_q;
    assign shifter_in   = shifter_in_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign illegal      = illegal_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: behavioural shift register plus a reference model of shift results and timing.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        use_var;
    logic [4:0]  shamt;
    logic [31:0] rs_amt;
    logic [31:0] data_in;
    logic [31:0] shifter_out;
    logic [2:0]  shifter_ctrl;
    logic [4:0]  shifter_n;
    logic [31:0] shifter_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        illegal;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_result = 32'd0;
    logic [31:0] shreg;

    shift_sequencer #(.SKIP_ZERO(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .use_var(use_var),
        .shamt(shamt), .rs_amt(rs_amt), .data_in(data_in), .shifter_out(shifter_out),
        .shifter_ctrl(shifter_ctrl), .shifter_n(shifter_n), .shifter_in(shifter_in),
        .busy(busy), .done(done), .result(result), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Behavioural shift register driven by the sequencer's commands.
    always @(posedge clk) begin
        if (reset) shreg <= 32'd0;
        else case (shifter_ctrl)
            3'b001: shreg <= shifter_in;
            3'b010: shreg <= shreg << shifter_n;
            3'b011: shreg <= shreg >> shifter_n;
            3'b100: shreg <= $signed(shreg) >>> shifter_n;
            default: ;
        endcase
    end
    assign shifter_out = shreg;

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d, input logic [4:0] a);
        case (o)
            2'd0:    return d << a;
            2'd1:    return d >> a;
            default: return $signed(d) >>> a;
        endcase
    endfunction

    task automatic scramble_inputs();
        op = 2'($urandom); use_var = 1'($urandom); shamt = 5'($urandom);
        rs_amt = $urandom; data_in = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        scramble_inputs();
        repeat (2) @(negedge clk);
        checks += 7;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
        if (shifter_ctrl !== 3'b000) begin failures++; $display("FAIL reset_ctrl: got %b expected 000", shifter_ctrl); end
        if (shifter_n !== 5'd0) begin failures++; $display("FAIL reset_n: got %0d expected 0", shifter_n); end
        if (shifter_in !== 32'd0) begin failures++; $display("FAIL reset_in: got %h expected 0", shifter_in); end
        if (result !== 32'd0) begin failures++; $display("FAIL reset_result: got %h expected 0", result); end
        reset = 1'b0;
        last_result = 32'd0;
    endtask

    // One operation from the start cycle to the IDLE cycle after done; poke re-asserts start mid-operation.
    task automatic run_op(input logic [1:0] o, input logic uv, input logic [4:0] sh,
                          input logic [31:0] rs, input logic [31:0] d, input bit poke);
        logic [4:0]  amt;
        logic [31:0] exp_r;
        logic [2:0]  exp_ctrl;
        int          lat;
        amt   = uv ? rs[4:0] : sh;
        exp_r = ref_shift(o, d, amt);
        lat   = (amt == 5'd0) ? 3 : 4;
        @(negedge clk);
        start = 1'b1; op = o; use_var = uv; shamt = sh; rs_amt = rs; data_in = d;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                scramble_inputs();
                checks += 2;
                if (shifter_n !== amt) begin failures++; $display("FAIL op_amount: got %0d expected %0d", shifter_n, amt); end
                if (shifter_in !== d) begin failures++; $display("FAIL op_load_data: got %h expected %h", shifter_in, d); end
            end
            if (poke && c == 2) start = 1'b1;
            if (c == 3) start = 1'b0;
            exp_ctrl = (c == 1) ? 3'b001 : ((c == 2 && lat == 4) ? ({1'b0, o} + 3'd2) : 3'b000);
            checks += 4;
            if (shifter_ctrl !== exp_ctrl) begin failures++; $display("FAIL op_ctrl c=%0d: got %b expected %b", c, shifter_ctrl, exp_ctrl); end
            if (done !== (c == lat)) begin failures++; $display("FAIL op_done c=%0d: got %b expected %b", c, done, c == lat); end
            if (busy !== (c <= lat)) begin failures++; $display("FAIL op_busy c=%0d: got %b expected %b", c, busy, c <= lat); end
            if (illegal !== 1'b0) begin failures++; $display("FAIL op_illegal c=%0d: got %b expected 0", c, illegal); end
            if (c >= lat) begin
                checks++;
                if (result !== exp_r) begin failures++; $display("FAIL op_result c=%0d: got %h expected %h", c, result, exp_r); end
            end
            if (c == lat + 1) begin
                checks++;
                if (shifter_n !== amt) begin failures++; $display("FAIL op_n_hold: got %0d expected %0d", shifter_n, amt); end
            end
        end
        last_result = exp_r;
    endtask

    task automatic test_directed();
        run_op(2'b00, 1'b0, 5'd4, 32'd0, 32'h0000_000F, 1'b0);
        checks++;
        if (result !== 32'h0000_00F0) begin failures++; $display("FAIL sll4: got %h expected 000000f0", result); end
        run_op(2'b10, 1'b1, 5'd0, 32'hFFFF_FFE8, 32'h8000_0000, 1'b0);
        checks++;
        if (result !== 32'hFF80_0000) begin failures++; $display("FAIL sra8: got %h expected ff800000", result); end
        run_op(2'b01, 1'b0, 5'd0, 32'd0, 32'h1234_5678, 1'b0);
        checks++;
        if (result !== 32'h1234_5678) begin failures++; $display("FAIL srl0: got %h expected 12345678", result); end
        run_op(2'b00, 1'b1, 5'd3, 32'h0000_001F, 32'h0000_0001, 1'b0);
        checks++;
        if (result !== 32'h8000_0000) begin failures++; $display("FAIL sll31: got %h expected 80000000", result); end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        scramble_inputs();
        start = 1'b1; op = 2'b11;
        @(negedge clk);
        start = 1'b0;
        checks += 4;
        if (illegal !== 1'b1) begin failures++; $display("FAIL illegal_pulse: got %b expected 1", illegal); end
        if (busy !== 1'b0) begin failures++; $display("FAIL illegal_busy: got %b expected 0", busy); end
        if (shifter_ctrl !== 3'b000) begin failures++; $display("FAIL illegal_ctrl: got %b expected 000", shifter_ctrl); end
        if (result !== last_result) begin failures++; $display("FAIL illegal_result: got %h expected %h", result, last_result); end
        @(negedge clk);
        checks += 3;
        if (illegal !== 1'b0) begin failures++; $display("FAIL illegal_once: got %b expected 0", illegal); end
        if (busy !== 1'b0) begin failures++; $display("FAIL illegal_busy2: got %b expected 0", busy); end
        if (result !== last_result) begin failures++; $display("FAIL illegal_result2: got %h expected %h", result, last_result); end
    endtask

    task automatic test_reset_mid();
        int dones;
        @(negedge clk);
        start = 1'b1; op = 2'b00; use_var = 1'b0; shamt = 5'd5; data_in = $urandom | 32'h1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (shifter_ctrl !== 3'b010) begin failures++; $display("FAIL mid_in_shift: got %b expected 010", shifter_ctrl); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b expected 0", busy); end
        if (shifter_ctrl !== 3'b000) begin failures++; $display("FAIL mid_ctrl: got %b expected 000", shifter_ctrl); end
        if (result !== 32'd0) begin failures++; $display("FAIL mid_result: got %h expected 0", result); end
        if (done !== 1'b0) begin failures++; $display("FAIL mid_done: got %b expected 0", done); end
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin failures++; $display("FAIL mid_no_done: got %0d pulses expected 0", dones); end
        last_result = 32'd0;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  o;
        logic [31:0] d;
        logic [4:0]  a;
        int          lat;
        o = 2'($urandom_range(0, 2)); d = $urandom; a = 5'($urandom_range(0, 31));
        @(negedge clk);
        start = 1'b1; op = o; use_var = 1'b0; shamt = a; data_in = d;
        for (int k = 0; k < 4; k++) begin
            lat = (a == 5'd0) ? 3 : 4;
            for (int c = 1; c <= lat + 1; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    checks += 2;
                    if (shifter_ctrl !== 3'b001) begin failures++; $display("FAIL b2b_accept k=%0d: got %b expected 001", k, shifter_ctrl); end
                    if (shifter_in !== d) begin failures++; $display("FAIL b2b_data k=%0d: got %h expected %h", k, shifter_in, d); end
                    op = 2'($urandom); data_in = $urandom; shamt = 5'($urandom);
                end
                checks += 2;
                if (done !== (c == lat)) begin failures++; $display("FAIL b2b_done k=%0d c=%0d: got %b expected %b", k, c, done, c == lat); end
                if (busy !== (c <= lat)) begin failures++; $display("FAIL b2b_busy k=%0d c=%0d: got %b expected %b", k, c, busy, c <= lat); end
                if (c == lat) begin
                    checks++;
                    if (result !== ref_shift(o, d, a)) begin failures++; $display("FAIL b2b_result k=%0d: got %h expected %h", k, result, ref_shift(o, d, a)); end
                    last_result = ref_shift(o, d, a);
                    o = 2'($urandom_range(0, 2)); d = $urandom; a = 5'($urandom_range(0, 31));
                    op = o; data_in = d; shamt = a;
                    if (k == 3) start = 1'b0;
                end
            end
        end
    endtask

    task automatic test_random();
        logic [4:0]  sh;
        logic [31:0] rs;
        for (int i = 0; i < 30; i++) begin
            sh = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rs = $urandom;
            if ($urandom_range(0, 3) == 0) rs[4:0] = 5'd0;
            run_op(2'($urandom_range(0, 2)), 1'($urandom), sh, rs, $urandom, 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_reset_mid();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
